// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Shares the single register-file write port between an in-order pipeline
// writeback (source A, normal priority) and a long-latency unit (source B).
// A wins by default. A starvation guard counts consecutive cycles in which B
// waits while A is also valid; after STARVE_LIMIT of them, B is forced through
// for one grant. The accepted write is registered before it reaches the
// register file. Writes to x0 are accepted but issued with the enable low.

// Protocol properties observed at the arbiter boundary.
module regfile_wr_arbiter_chk #(
   parameter int ADDRESS_WIDTH = 5
) (
   input logic                     clk,
   input logic                     rst,
   input logic                     a_valid,
   input logic                     a_ready,
   input logic                     b_valid,
   input logic                     b_ready,
   input logic                     b_forced,
   input logic                     rg_wrt_en,
   input logic [ADDRESS_WIDTH-1:0] rg_wrt_dest
);

   // Only one source may complete a handshake in any cycle.
   a_one_accept: assert property (@(posedge clk) disable iff (!rst)
      !(a_valid && a_ready && b_valid && b_ready));

   // The forced-grant state blocks A.
   a_force_blocks_a: assert property (@(posedge clk) disable iff (!rst)
      b_forced |-> !a_ready);

   // A forced grant lasts a single cycle.
   a_force_one_cycle: assert property (@(posedge clk) disable iff (!rst)
      b_forced |=> !b_forced);

   // Register x0 is never written.
   a_no_x0_write: assert property (@(posedge clk) disable iff (!rst)
      rg_wrt_en |-> (rg_wrt_dest != '0));

endmodule

module regfile_wr_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     a_valid,
   output logic                     a_ready,
   input  logic [ADDRESS_WIDTH-1:0] a_dest,
   input  logic [DATA_WIDTH-1:0]    a_data,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [ADDRESS_WIDTH-1:0] b_dest,
   input  logic [DATA_WIDTH-1:0]    b_data,
   output logic                     rg_wrt_en,
   output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
   output logic [DATA_WIDTH-1:0]    rg_wrt_data,
   output logic                     b_forced
);

   localparam int                CNT_W     = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic [0:0] {
      PRIO_A  = 1'b0,
      FORCE_B = 1'b1
   } state_e;

   // A destination of x0 is architecturally discarded.
   function automatic logic is_x0(input logic [ADDRESS_WIDTH-1:0] dest);
      return (dest == '0);
   endfunction

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         wait_cnt_q, wait_cnt_d;
   logic                     rg_wrt_en_q, rg_wrt_en_d;
   logic [ADDRESS_WIDTH-1:0] rg_wrt_dest_q, rg_wrt_dest_d;
   logic [DATA_WIDTH-1:0]    rg_wrt_data_q, rg_wrt_data_d;

   logic                     a_ready_s;
   logic                     b_ready_s;
   logic                     b_forced_s;
   logic                     a_acc_s;
   logic                     b_acc_s;
   logic [CNT_W-1:0]         cnt_inc_s;

   // Arbitration FSM: ready generation, starvation counting and next state.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      a_ready_s  = 1'b0;
      b_ready_s  = 1'b0;
      b_forced_s = 1'b0;
      // Saturating increment so the counter can never wrap.
      if (wait_cnt_q == CNT_MAX) begin
         cnt_inc_s = wait_cnt_q;
      end else begin
         cnt_inc_s = wait_cnt_q + CNT_ONE;
      end
      case (state_q)
         PRIO_A: begin
            a_ready_s = 1'b1;
            b_ready_s = ~a_valid;
            if (a_valid && b_valid) begin
               // B lost this cycle to A.
               if (cnt_inc_s == CNT_LIMIT) begin
                  state_d    = FORCE_B;
                  wait_cnt_d = '0;
               end else begin
                  wait_cnt_d = cnt_inc_s;
               end
            end else begin
               // B was served or had nothing pending.
               wait_cnt_d = '0;
            end
         end
         FORCE_B: begin
            b_ready_s  = 1'b1;
            b_forced_s = 1'b1;
            wait_cnt_d = '0;
            if (b_valid) begin
               // B is accepted this cycle; A regains priority.
               state_d = PRIO_A;
            end else begin
               // B withdrew its request; nothing to force.
               state_d = PRIO_A;
            end
         end
         default: begin
            state_d    = PRIO_A;
            wait_cnt_d = '0;
         end
      endcase
   end

   assign a_acc_s = a_valid & a_ready_s;
   assign b_acc_s = b_valid & b_ready_s;

   // Select the accepted write for the output register; hold address/data when idle.
   always_comb begin
      rg_wrt_en_d   = 1'b0;
      rg_wrt_dest_d = rg_wrt_dest_q;
      rg_wrt_data_d = rg_wrt_data_q;
      if (a_acc_s) begin
         rg_wrt_en_d   = ~is_x0(a_dest);
         rg_wrt_dest_d = a_dest;
         rg_wrt_data_d = a_data;
      end else if (b_acc_s) begin
         rg_wrt_en_d   = ~is_x0(b_dest);
         rg_wrt_dest_d = b_dest;
         rg_wrt_data_d = b_data;
      end else begin
         rg_wrt_en_d   = 1'b0;
      end
   end

   // State, starvation counter and write-port output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= PRIO_A;
         wait_cnt_q    <= '0;
         rg_wrt_en_q   <= 1'b0;
         rg_wrt_dest_q <= '0;
         rg_wrt_data_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         rg_wrt_en_q   <= rg_wrt_en_d;
         rg_wrt_dest_q <= rg_wrt_dest_d;
         rg_wrt_data_q <= rg_wrt_data_d;
      end
   end

   assign a_ready     = a_ready_s;
   assign b_ready     = b_ready_s;
   assign b_forced    = b_forced_s;
   assign rg_wrt_en   = rg_wrt_en_q;
   assign rg_wrt_dest = rg_wrt_dest_q;
   assign rg_wrt_data = rg_wrt_data_q;

   regfile_wr_arbiter_chk #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_chk (
      .clk        (clk),
      .rst        (rst),
      .a_valid    (a_valid),
      .a_ready    (a_ready_s),
      .b_valid    (b_valid),
      .b_ready    (b_ready_s),
      .b_forced   (b_forced_s),
      .rg_wrt_en  (rg_wrt_en_q),
      .rg_wrt_dest(rg_wrt_dest_q)
   );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus randomized traffic,
// with a reference model predicting grants and a scoreboard comparing issued writes.
module tb_regfile_wr_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          a_valid = 1'b0, b_valid = 1'b0;
   logic          a_ready, b_ready;
   logic [AW-1:0] a_dest = '0, b_dest = '0;
   logic [DW-1:0] a_data = '0, b_data = '0;
   logic          rg_wrt_en;
   logic [AW-1:0] rg_wrt_dest;
   logic [DW-1:0] rg_wrt_data;
   logic          b_forced;

   regfile_wr_arbiter #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
      .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
      .b_forced(b_forced)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] dest;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           a_src_q[$];
   wr_t           b_src_q[$];
   wr_t           exp_q[$];
   logic [DW-1:0] ref_rf[32];
   logic [DW-1:0] dut_rf[32];

   int checks = 0;
   int passed = 0;

   // reference model: B's wait is a count of lost cycles; forced grant is a flag
   bit m_forced = 1'b0;
   int m_losses = 0;
   bit m_exp_en = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   // Reference model: decides who is granted at each edge from the arbitration rules.
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_forced = 1'b0;
            m_losses = 0;
            m_exp_en = 1'b0;
            exp_q.delete();
         end else begin
            bit  ga, gb;
            wr_t w;
            ga = a_valid && !m_forced;
            gb = b_valid && (m_forced || !a_valid);
            m_exp_en = 1'b0;
            if (ga || gb) begin
               w.dest = ga ? a_dest : b_dest;
               w.data = ga ? a_data : b_data;
               if (w.dest != '0) begin
                  exp_q.push_back(w);
                  m_exp_en = 1'b1;
               end
            end
            if (m_forced) begin
               m_forced = 1'b0;
               m_losses = 0;
            end else if (a_valid && b_valid) begin
               m_losses = m_losses + 1;
               if (m_losses >= SL) begin
                  m_forced = 1'b1;
                  m_losses = 0;
               end
            end else begin
               m_losses = 0;
            end
         end
      end
   end

   // Monitor: compares handshake outputs and pops the scoreboard on every issued write.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            wr_t w;
            check("a_ready", a_ready, !m_forced);
            check("b_ready", b_ready, m_forced || !a_valid);
            check("b_forced", b_forced, m_forced);
            check("rg_wrt_en", rg_wrt_en, m_exp_en);
            if (rg_wrt_en) begin
               dut_rf[rg_wrt_dest] = rg_wrt_data;
               if (exp_q.size() == 0) begin
                  check("unexpected_write", 1, 0);
               end else begin
                  w = exp_q.pop_front();
                  check("wr_dest", rg_wrt_dest, w.dest);
                  check("wr_data", rg_wrt_data, w.data);
                  ref_rf[w.dest] = w.data;
               end
            end
         end
      end
   end

   // One clock of source behaviour: record handshakes, then present the next queued write.
   task automatic tick();
      bit  at, bt;
      wr_t w;
      @(negedge clk);
      at = rst && a_valid && a_ready;
      bt = rst && b_valid && b_ready;
      @(posedge clk);
      #1;
      if (at || !a_valid) begin
         if (a_src_q.size() > 0) begin
            w = a_src_q.pop_front();
            a_valid = 1'b1; a_dest = w.dest; a_data = w.data;
         end else begin
            a_valid = 1'b0;
         end
      end
      if (bt || !b_valid) begin
         if (b_src_q.size() > 0) begin
            w = b_src_q.pop_front();
            b_valid = 1'b1; b_dest = w.dest; b_data = w.data;
         end else begin
            b_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic drain();
      int budget = 300;
      while ((a_valid || b_valid || a_src_q.size() > 0 || b_src_q.size() > 0) && budget > 0) begin
         tick();
         budget--;
      end
      check("drain_done", {31'd0, (a_valid || b_valid)}, 0);
      tick();
      tick();
   endtask

   function automatic wr_t mk(input int d, input logic [DW-1:0] v);
      wr_t w;
      w.dest = AW'(d);
      w.data = v;
      return w;
   endfunction

   // Watchdog so a stuck design still ends the run.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus sequence.
   initial begin
      int mism;
      for (int i = 0; i < 32; i++) begin
         ref_rf[i] = '0;
         dut_rf[i] = '0;
      end

      // reset state
      @(posedge clk);
      #1;
      check("rst_en", rg_wrt_en, 0);
      check("rst_dest", rg_wrt_dest, 0);
      check("rst_data", rg_wrt_data, 0);
      check("rst_forced", b_forced, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      tick();

      // A only, back-to-back
      for (int i = 1; i <= 4; i++) a_src_q.push_back(mk(i, 32'hA0 + DW'(i)));
      tick();
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("a_only_en", rg_wrt_en, 1);
         check("a_only_dest", rg_wrt_dest, DW'(i));
         check("a_only_data", rg_wrt_data, 32'hA0 + DW'(i));
      end
      drain();

      // reset asserted mid-stream with A valid
      a_src_q.push_back(mk(1, 32'h21));
      a_src_q.push_back(mk(2, 32'h22));
      a_src_q.push_back(mk(6, 32'h26));
      a_src_q.push_back(mk(8, 32'h28));
      tick(); tick(); tick();
      rst = 1'b0;
      #1;
      check("midrst_en", rg_wrt_en, 0);
      check("midrst_dest", rg_wrt_dest, 0);
      check("midrst_data", rg_wrt_data, 0);
      check("midrst_forced", b_forced, 0);
      a_src_q.delete();
      b_src_q.delete();
      b_valid = 1'b0;
      a_valid = 1'b1; a_dest = 5'd3; a_data = 32'h11;
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_en", rg_wrt_en, 1);
      check("post_rst_dest", rg_wrt_dest, 3);
      check("post_rst_data", rg_wrt_data, 32'h11);
      drain();

      // starvation: A always valid, B waits STARVE_LIMIT cycles then is forced
      for (int i = 0; i < 10; i++) a_src_q.push_back(mk(10 + i, $urandom));
      b_src_q.push_back(mk(7, 32'hBEEF));
      tick();
      for (int c = 1; c <= SL; c++) begin
         check("starve_b_ready", b_ready, 0);
         check("starve_forced", b_forced, 0);
         tick();
      end
      check("force_a_ready", a_ready, 0);
      check("force_b_ready", b_ready, 1);
      check("force_flag", b_forced, 1);
      tick();
      check("force_wr_en", rg_wrt_en, 1);
      check("force_wr_dest", rg_wrt_dest, 7);
      check("force_wr_data", rg_wrt_data, 32'hBEEF);
      check("force_exit", b_forced, 0);
      check("a_resumes", a_ready, 1);
      drain();

      // B only
      b_src_q.push_back(mk(9, 32'h5));
      tick();
      check("b_only_ready", b_ready, 1);
      tick();
      check("b_only_en", rg_wrt_en, 1);
      check("b_only_dest", rg_wrt_dest, 9);
      check("b_only_data", rg_wrt_data, 32'h5);
      drain();

      // x0 write is accepted but not issued
      a_src_q.push_back(mk(0, 32'hFFFF));
      tick();
      check("x0_ready", a_ready, 1);
      tick();
      check("x0_en", rg_wrt_en, 0);
      drain();

      // same destination from both sources
      a_src_q.push_back(mk(5, 32'h1));
      b_src_q.push_back(mk(5, 32'h2));
      tick();
      tick();
      check("coll_first_en", rg_wrt_en, 1);
      check("coll_first_data", rg_wrt_data, 32'h1);
      tick();
      check("coll_second_en", rg_wrt_en, 1);
      check("coll_second_data", rg_wrt_data, 32'h2);
      tick();
      check("coll_reg5", dut_rf[5], 32'h2);
      drain();

      // randomized traffic at several contention levels
      for (int ph = 0; ph < 3; ph++) begin
         int pa, pb;
         pa = (ph == 0) ? 90 : (ph == 1) ? 50 : 100;
         pb = (ph == 0) ? 40 : (ph == 1) ? 50 : 100;
         for (int n = 0; n < 300; n++) begin
            if ($urandom_range(99) < pa && a_src_q.size() < 4)
               a_src_q.push_back(mk(int'($urandom_range(31)), $urandom));
            if ($urandom_range(99) < pb && b_src_q.size() < 4)
               b_src_q.push_back(mk(int'($urandom_range(31)), $urandom));
            tick();
         end
         drain();
      end

      // final scoreboard state
      check("exp_q_empty", exp_q.size(), 0);
      mism = 0;
      for (int i = 0; i < 32; i++) if (dut_rf[i] !== ref_rf[i]) mism++;
      check("rf_match", mism, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
